// File: rtl/vga_sync_receiver.sv
// TinyVGA PMOD stream receiver: locks a beam tracker to incoming syncs and
// recovers per-pixel position, colour and line/frame timing measurements.
module vga_sync_receiver #(
    parameter int H_DISPLAY    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_TOTAL      = 800,
    parameter int V_DISPLAY    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic        locked,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        display_on,
    output logic [5:0]  rgb,
    output logic        line_start,
    output logic        frame_start,
    output logic [10:0] h_total_meas,
    output logic [9:0]  v_total_meas,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam logic [9:0]  H_DISP  = 10'(H_DISPLAY);
    localparam logic [9:0]  H_SYNC  = 10'(H_SYNC_START);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [9:0]  V_DISP  = 10'(V_DISPLAY);
    localparam logic [9:0]  V_SYNC  = 10'(V_SYNC_START);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
    localparam logic [10:0] HCNT_MAX = 11'h7ff;
    localparam logic [9:0]  VCNT_MAX = 10'h3ff;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t      state, state_n;
    logic [7:0]  s;
    logic [9:0]  hpos_n, vpos_n;
    logic [10:0] hcnt, hcnt_n;
    logic [9:0]  vcnt, vcnt_n;
    logic        first_h, first_h_n;
    logic        vs_seen, vs_seen_n;
    logic [10:0] htm_n;
    logic [9:0]  vtm_n;
    logic        err_n;
    logic        mismatch;

    // Edges of the sample about to become S, so every register loaded this
    // clk already describes that sample.
    logic hs_rise, vs_rise;
    assign hs_rise = vga_in[7] & ~s[7];
    assign vs_rise = vga_in[3] & ~s[3];

    logic       h_wrap;
    logic [9:0] h_adv, v_adv;
    logic [10:0] hcnt_inc;
    logic [9:0]  vcnt_inc;
    logic        lock_ok, sync_point;

    assign h_wrap   = (hpos == H_LAST);
    assign h_adv    = h_wrap ? 10'd0 : hpos + 10'd1;
    assign v_adv    = !h_wrap ? vpos :
                      (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    assign hcnt_inc = (hcnt == HCNT_MAX) ? hcnt : hcnt + 11'd1;
    assign vcnt_inc = (vcnt == VCNT_MAX) ? vcnt : vcnt + 10'd1;
    assign lock_ok  = (h_total_meas == H_TOT) && (vcnt == V_TOT) && !first_h;
    assign sync_point = (h_adv == H_SYNC) && (v_adv == V_SYNC);

    always_comb begin
        state_n   = state;
        hpos_n    = hpos;
        vpos_n    = vpos;
        hcnt_n    = hcnt;
        vcnt_n    = vcnt;
        first_h_n = first_h;
        vs_seen_n = vs_seen;
        htm_n     = h_total_meas;
        vtm_n     = v_total_meas;
        err_n     = 1'b0;
        mismatch  = 1'b0;
        unique case (state)
            SEARCH: begin
                hpos_n    = 10'd0;
                vpos_n    = 10'd0;
                hcnt_n    = 11'd0;
                vcnt_n    = 10'd0;
                vs_seen_n = 1'b0;
                if (vs_rise) begin
                    state_n   = MEASURE;
                    vpos_n    = V_SYNC;
                    first_h_n = 1'b1;
                    vs_seen_n = 1'b1;
                end
            end
            MEASURE, LOCKED: begin
                hpos_n    = h_adv;
                vpos_n    = v_adv;
                hcnt_n    = hcnt_inc;
                vs_seen_n = vs_seen | vs_rise;
                if (hs_rise) begin
                    vcnt_n = vcnt_inc;
                    hcnt_n = 11'd0;
                    if (first_h) begin
                        hpos_n    = H_SYNC;
                        first_h_n = 1'b0;
                    end else begin
                        htm_n = hcnt + 11'd1;
                    end
                end
                // A coincident hsync edge already belongs to the new frame.
                if (vs_rise) begin
                    vtm_n  = vcnt;
                    vcnt_n = hs_rise ? 10'd1 : 10'd0;
                    vpos_n = V_SYNC;
                end
                if (state == MEASURE) begin
                    if (hcnt == HCNT_MAX || vcnt == VCNT_MAX) begin
                        err_n   = 1'b1;
                        state_n = SEARCH;
                    end else if (vs_rise) begin
                        if (lock_ok) begin
                            state_n = LOCKED;
                        end else begin
                            err_n   = 1'b1;
                            state_n = SEARCH;
                        end
                    end
                end else begin
                    if (hs_rise != (h_adv == H_SYNC))
                        mismatch = 1'b1;
                    if (vs_rise && v_adv != V_SYNC)
                        mismatch = 1'b1;
                    // vsync must have risen somewhere on its line by hsync.
                    if (sync_point) begin
                        if (!vs_seen_n)
                            mismatch = 1'b1;
                        vs_seen_n = 1'b0;
                    end
                    if (mismatch) begin
                        err_n   = 1'b1;
                        state_n = SEARCH;
                    end
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SEARCH;
            s            <= 8'd0;
            locked       <= 1'b0;
            hpos         <= 10'd0;
            vpos         <= 10'd0;
            hcnt         <= 11'd0;
            vcnt         <= 10'd0;
            first_h      <= 1'b0;
            vs_seen      <= 1'b0;
            h_total_meas <= 11'd0;
            v_total_meas <= 10'd0;
            err          <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            state        <= state_n;
            s            <= vga_in;
            locked       <= (state == LOCKED);
            hpos         <= hpos_n;
            vpos         <= vpos_n;
            hcnt         <= hcnt_n;
            vcnt         <= vcnt_n;
            first_h      <= first_h_n;
            vs_seen      <= vs_seen_n;
            h_total_meas <= htm_n;
            v_total_meas <= vtm_n;
            err          <= err_n;
            if (err_n && err_count != 8'hff)
                err_count <= err_count + 8'd1;
        end
    end

    assign display_on  = locked && (hpos < H_DISP) && (vpos < V_DISP);
    assign rgb         = display_on ? {s[0], s[4], s[1], s[5], s[2], s[6]}
                                    : 6'd0;
    assign line_start  = locked && (hpos == 10'd0);
    assign frame_start = line_start && (vpos == 10'd0);

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down 32x14 raster
// (16x8 visible, hsync 20..23, vsync lines 10..11).
module tb_vga_sync_receiver;

    localparam int HD = 16;
    localparam int HS = 20;
    localparam int HT = 32;
    localparam int VD = 8;
    localparam int VS = 10;
    localparam int VT = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vga_in = 8'd0;
    logic        locked;
    logic [9:0]  hpos, vpos;
    logic        display_on;
    logic [5:0]  rgb;
    logic        line_start, frame_start;
    logic [10:0] h_total_meas;
    logic [9:0]  v_total_meas;
    logic        err;
    logic [7:0]  err_count;

    vga_sync_receiver #(
        .H_DISPLAY(HD), .H_SYNC_START(HS), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_SYNC_START(VS), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
        .locked(locked), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .rgb(rgb),
        .line_start(line_start), .frame_start(frame_start),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int sh, sv, htot, cur_h, cur_v;
    bit glitch_en = 0;
    bit use_ovr = 0;
    logic [7:0] ovr = 8'd0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] color(int h, int v);
        if (h == 0 && v == 0)
            return 6'b111010;
        return 6'((h * 3 + v * 5) ^ 42);
    endfunction

    function automatic logic [7:0] pix(int h, int v);
        logic [5:0] c;
        logic hs, vs;
        c  = color(h, v);
        hs = (h >= HS && h < HS + 4) || (glitch_en && h == 5 && v == 3);
        vs = (v >= VS && v < VS + 2);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    function automatic logic [59:0] all_out();
        return {locked, hpos, vpos, display_on, rgb, line_start,
                frame_start, h_total_meas, v_total_meas, err, err_count};
    endfunction

    task automatic tick();
        vga_in = use_ovr ? ovr : pix(sh, sv);
        @(posedge clk);
        #1;
        cur_h = sh;
        cur_v = sv;
        if (sh == htot - 1) begin
            sh = 0;
            sv = (sv == VT - 1) ? 0 : sv + 1;
        end else begin
            sh++;
        end
    endtask

    function automatic bit at_vs();
        return cur_h == 0 && cur_v == VS;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_vs, errs, bad_pos, bad_px, fs, ls, unlk, early, k, lk, evs;
        logic [5:0] exp_rgb;
        logic exp_d;

        // Reset
        sh = 0; sv = 3; htot = HT;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", all_out(), 64'd0);

        // Nominal stream, mid-frame start
        rst_n = 1'b1;
        n_vs = 0; early = 0;
        for (int i = 0; i < 2000 && n_vs < 2; i++) begin
            tick();
            if (at_vs()) n_vs++;
            early += int'(locked);
        end
        check("lock_vs_count", n_vs, 2);
        check("no_early_lock", early, 0);
        tick();
        check("lock_one_after_vs", locked, 1'b1);
        check("lock_pos", {hpos, vpos}, {10'd1, 10'(VS)});
        check("h_total_meas", h_total_meas, 11'(HT));
        check("v_total_meas", v_total_meas, 10'(VT));
        check("nominal_err_count", err_count, 8'd0);

        bad_pos = 0; bad_px = 0; fs = 0; ls = 0; errs = 0; unlk = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            if (hpos !== cur_h[9:0] || vpos !== cur_v[9:0]) bad_pos++;
            exp_d   = (cur_h < HD) && (cur_v < VD);
            exp_rgb = exp_d ? color(cur_h, cur_v) : 6'd0;
            if (display_on !== exp_d || rgb !== exp_rgb) bad_px++;
            if (line_start !== (cur_h == 0)) bad_px++;
            fs += int'(frame_start);
            ls += int'(line_start);
            errs += int'(err);
            unlk += int'(!locked);
            if (cur_h == 0 && cur_v == 0) begin
                check("rgb_at_origin", {hpos, vpos, rgb},
                      {10'd0, 10'd0, 6'b111010});
                check("frame_start_origin", frame_start, 1'b1);
            end
            if (cur_h == 28 && cur_v == 2)
                check("rgb_blank", {display_on, rgb}, 7'd0);
        end
        check("pos_track", bad_pos, 0);
        check("pixel_track", bad_px, 0);
        check("frame_starts", fs, 1);
        check("line_starts", ls, VT);
        check("nominal_no_err", errs, 0);
        check("stays_locked", unlk, 0);

        // Extra 1-clk hsync at x=5, y=3
        glitch_en = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cur_h == 5 && cur_v == 3) break;
        end
        check("glitch_err", {err, locked}, 2'b11);
        glitch_en = 0;
        tick();
        check("glitch_unlock", {err, locked}, 2'b00);
        check("glitch_err_count", err_count, 8'd1);
        n_vs = 0;
        for (int i = 0; i < 2000 && !locked; i++) begin
            tick();
            if (at_vs()) n_vs++;
        end
        check("relock_vs_count", n_vs, 2);
        check("relock_pos", {cur_h[9:0], cur_v[9:0], locked},
              {10'd1, 10'(VS), 1'b1});
        check("relock_err_count", err_count, 8'd1);

        // Reset pulse while locked
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (cur_h == 6 && cur_v == 3) break;
        end
        rst_n = 1'b0;
        tick();
        check("midrun_reset", all_out(), 64'd0);
        rst_n = 1'b1;
        n_vs = 0; errs = 0;
        for (int i = 0; i < 2000 && !locked; i++) begin
            tick();
            if (at_vs()) n_vs++;
            errs += int'(err);
        end
        check("reset_relock_vs", n_vs, 2);
        check("reset_relock", {locked, err_count}, {1'b1, 8'd0});
        check("reset_no_err", errs, 0);

        // 31-clock lines
        rst_n = 1'b0;
        sh = 0; sv = 3; htot = HT - 1;
        repeat (2) tick();
        rst_n = 1'b1;
        n_vs = 0; errs = 0; evs = 0; lk = 0;
        for (int i = 0; i < 5000 && n_vs < 4; i++) begin
            tick();
            if (at_vs()) begin
                n_vs++;
                evs += int'(err);
            end
            errs += int'(err);
            lk += int'(locked);
        end
        check("short_vs_count", n_vs, 4);
        check("short_err_pulses", errs, 2);
        check("short_err_at_vs", evs, 2);
        check("short_never_locked", lk, 0);
        check("short_err_count", err_count, 8'd2);
        check("short_h_meas", h_total_meas, 11'(HT - 1));
        check("short_v_meas", v_total_meas, 10'(VT));

        // Silent input, then a lone vsync
        rst_n = 1'b0;
        use_ovr = 1; ovr = 8'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        lk = 0; errs = 0;
        repeat (3000) begin
            tick();
            lk += int'(locked);
            errs += int'(err);
        end
        check("silent_locked", lk, 0);
        check("silent_err", {errs[7:0], err_count}, 16'd0);
        ovr = 8'h08;
        tick();
        ovr = 8'd0;
        k = 0;
        for (int i = 0; i < 2100; i++) begin
            tick();
            k++;
            if (err) break;
        end
        check("timeout_latency", k, 2048);
        check("timeout_err_count", {locked, err_count}, {1'b0, 8'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receiver/decoder for the TinyVGA PMOD pin bundle produced by the team's VGA pattern designs.
- Samples the 8-bit PMOD bus, detects hsync/vsync edges and measures line/frame timing.
- Locks a local beam-position tracker to the incoming stream and recovers per-pixel hpos/vpos/display_on plus decoded 6-bit RGB.
- Used as an on-chip loopback checker and as the front end for stream-consuming (overlay/capture) blocks.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_SYNC_START, 656, hpos assigned to the first sample with hsync asserted
- H_TOTAL, 800, expected clocks per line
- V_DISPLAY, 480, visible lines per frame
- V_SYNC_START, 490, vpos assigned to the line on which vsync first asserts
- V_TOTAL, 525, expected lines per frame

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- vga_in  in  8  PMOD bus {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}; syncs active-high
- locked  out  1  position outputs valid
- hpos  out  10  recovered x of current rgb sample
- vpos  out  10  recovered y of current rgb sample
- display_on  out  1  locked && hpos<H_DISPLAY && vpos<V_DISPLAY
- rgb  out  6  {R[1:0],G[1:0],B[1:0]}; 0 when display_on=0
- line_start  out  1  one-cycle pulse when hpos wraps to 0 (locked only)
- frame_start  out  1  one-cycle pulse when hpos=0 and vpos=0 (locked only)
- h_total_meas  out  11  last measured clocks between hsync assert edges
- v_total_meas  out  10  last measured hsync edges between vsync assert edges
- err  out  1  one-cycle pulse on lock loss or measurement mismatch
- err_count  out  8  saturating error count

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. While rst_n=0, all outputs and internal state are 0 and the FSM is SEARCH.
- Input stage:
  - vga_in is registered once (sample S); the previous sample is held in S_d.
  - hs_edge = S.hsync & ~S_d.hsync. vs_edge = S.vsync & ~S_d.vsync.
  - Every output describes sample S, so latency from vga_in to outputs is exactly 1 clk.
- Position counters:
  - hpos increments each clk; after H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps V_TOTAL-1 -> 0.
- FSM states:
  - SEARCH:
    - hpos and vpos held at 0.
    - On vs_edge: go to MEASURE; load vpos=V_SYNC_START; clear hcnt and vcnt; set first_h=1.
  - MEASURE:
    - hcnt (11 bit) increments each clk and saturates at 2047.
    - On hs_edge with first_h=1: load hpos=H_SYNC_START, clear hcnt, clear first_h.
    - On hs_edge with first_h=0: h_total_meas<=hcnt+1, clear hcnt.
    - Every hs_edge increments vcnt (saturates at 1023).
    - On vs_edge: v_total_meas<=vcnt and vpos<=V_SYNC_START. If h_total_meas==H_TOTAL, vcnt==V_TOTAL and first_h=0, go to LOCKED. Otherwise pulse err and go to SEARCH.
    - hcnt==2047 or vcnt==1023: pulse err, go to SEARCH (timeout / no sync).
  - LOCKED:
    - Counters free-run.
    - A mismatch is any of:
      - hs_edge while hpos != H_SYNC_START
      - no hs_edge when hpos == H_SYNC_START
      - vs_edge while vpos != V_SYNC_START
      - no vs_edge when vpos == V_SYNC_START and hpos == H_SYNC_START
    - Mismatch: pulse err, locked drops the next clk, go to SEARCH.
    - h_total_meas and v_total_meas keep updating as in MEASURE.
- Simultaneous events: hs_edge and vs_edge in the same clk are both processed; vpos load takes priority over the vpos increment.
- locked is a registered copy of (state==LOCKED).
- err_count increments on every err pulse and saturates at 255.
- display_on, rgb, line_start and frame_start are forced to 0 whenever locked=0.
- Reset mid-operation: returns immediately to reset state; err is not pulsed and err_count is not incremented.

Test Plan:
1. Nominal 640x480 stream (800x525, hsync clocks 656-751, vsync lines 490-491) starting mid-frame -> locked=1 one clk after the second vs_edge; h_total_meas=800, v_total_meas=525; hpos/vpos equal the source counters delayed by 1 clk; frame_start once per 420000 clks; err_count=0.
2. Source with 799-clock lines -> h_total_meas=799, one err pulse per attempted frame, locked never 1, err_count increments each frame.
3. Locked stream, single extra 1-clk hsync pulse at hpos=100 -> err pulses once, locked=0, FSM re-locks after the next two vsync edges, err_count=1.
4. vga_in constant 0 -> locked=0; err_count stays 0 until a vs_edge; after one vs_edge followed by silence, timeout at hcnt=2047 gives err and err_count=1.
5. Locked stream, pixel at (0,0) = R=11 G=10 B=10 -> rgb=6'b111010 with hpos=0, vpos=0; rgb=0 during blanking (hpos=700).
6. rst_n low for 1 clk while locked -> next clk all outputs 0; re-lock requires a full MEASURE frame; err not pulsed.
